fft_frame_ctrl: RTL

Sequencer between the free-running NCO sample stream and the FFT core sink interface. It holds the FFT core in reset at start-up and after a sink error. It buffers the incoming samples in a shallow FIFO and frames them into FFT_LEN-point Avalon-ST packets, generating sink_valid/sop/eop. It also counts frames sent to the core and frames returned by it.

---
 rtl/fft_frame_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fft_frame_ctrl.sv
// Frames a free-running sample stream into FFT_LEN-point Avalon-ST packets for an FFT core.
// Also sequences the core's reset and counts the frames sent to the core and returned by it.
module fft_frame_ctrl #(
  parameter int FFT_LEN    = 1024,
  parameter int DATA_W     = 14,
  parameter int RST_CYCLES = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable_i,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              sample_valid_i,
  input  logic              sink_ready_i,
  input  logic [1:0]        sink_error_i,
  input  logic              source_valid_i,
  input  logic              source_eop_i,
  output logic              fft_reset_n_o,
  output logic              sink_valid_o,
  output logic              sink_sop_o,
  output logic              sink_eop_o,
  output logic [DATA_W-1:0] sink_real_o,
  output logic [DATA_W-1:0] sink_imag_o,
  output logic [15:0]       frames_in_o,
  output logic [15:0]       frames_out_o,
  output logic              busy_o,
  output logic              overflow_o,
  output logic              fault_o
);
  localparam int POS_W = $clog2(FFT_LEN);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(RST_CYCLES);

  typedef enum logic [1:0] {HOLD, IDLE, STREAM} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  hold_cnt;
  logic [POS_W-1:0]  pos, pos_nxt, wr_cnt;
  logic              stop_q;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic [DATA_W-1:0] head;
  logic              fifo_empty, fifo_full;
  logic              err, xfer, stopping, wr_req, load, pop, push, drop, flush;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign err      = (sink_error_i != 2'b00) && (state != HOLD);
  assign xfer     = sink_valid_o && sink_ready_i;
  assign stopping = (state == STREAM) && (stop_q || !enable_i);
  assign pos_nxt  = xfer ? pos + POS_W'(1) : pos;
  assign flush    = (state == HOLD) || err;

  // An empty FIFO is bypassed so a fresh sample reaches the sink register in one cycle.
  assign head = fifo_empty ? sample_i : mem[rd_ptr[AW-1:0]];
  assign load = !flush && (!fifo_empty || wr_req) && (!sink_valid_o || sink_ready_i);
  assign pop  = load && !fifo_empty;
  assign drop = wr_req && fifo_full && !pop;
  assign push = wr_req && !(fifo_empty && load) && !drop;

  assign busy_o      = (state == STREAM);
  assign sink_imag_o = '0;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    wr_req    = 1'b0;
    case (state)
      HOLD: begin
        if (hold_cnt == CNT_W'(RST_CYCLES - 1)) state_nxt = IDLE;
      end
      IDLE: begin
        wr_req = enable_i && sample_valid_i && !err;
        if (err)         state_nxt = HOLD;
        else if (wr_req) state_nxt = STREAM;
      end
      STREAM: begin
        // Once stopping, writes end after the last sample of the current frame.
        wr_req = sample_valid_i && !(stopping && wr_cnt == '0) && !err;
        if (err) state_nxt = HOLD;
        else if (stopping && wr_cnt == '0 && fifo_empty && xfer && sink_eop_o)
          state_nxt = IDLE;
      end
      default: state_nxt = HOLD;
    endcase
  end

  // NOTE: sample storage has no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= sample_i;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= HOLD;
      hold_cnt      <= '0;
      fft_reset_n_o <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      pos           <= '0;
      wr_cnt        <= '0;
      stop_q        <= 1'b0;
      sink_valid_o  <= 1'b0;
      sink_sop_o    <= 1'b0;
      sink_eop_o    <= 1'b0;
      sink_real_o   <= '0;
      frames_in_o   <= '0;
      frames_out_o  <= '0;
      overflow_o    <= 1'b0;
      fault_o       <= 1'b0;
    end else begin
      state         <= state_nxt;
      fft_reset_n_o <= (state_nxt != HOLD);
      hold_cnt      <= (state == HOLD) ? hold_cnt + CNT_W'(1) : '0;
      if (err)  fault_o    <= 1'b1;
      if (drop) overflow_o <= 1'b1;
      if (xfer && sink_eop_o) frames_in_o <= frames_in_o + 16'd1;
      if (state != HOLD && source_valid_i && source_eop_i)
        frames_out_o <= frames_out_o + 16'd1;

      if (flush) begin
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        pos          <= '0;
        wr_cnt       <= '0;
        stop_q       <= 1'b0;
        sink_valid_o <= 1'b0;
        sink_sop_o   <= 1'b0;
        sink_eop_o   <= 1'b0;
        sink_real_o  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
        if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        if (wr_req && !drop) wr_cnt <= wr_cnt + POS_W'(1);
        pos    <= pos_nxt;
        stop_q <= (state_nxt == STREAM) && stopping;
        if (load) begin
          sink_valid_o <= 1'b1;
          sink_sop_o   <= (pos_nxt == '0);
          sink_eop_o   <= (pos_nxt == POS_W'(FFT_LEN - 1));
          sink_real_o  <= head;
        end else if (xfer) begin
          sink_valid_o <= 1'b0;
          sink_sop_o   <= 1'b0;
          sink_eop_o   <= 1'b0;
        end
      end
    end
  end
endmodule
